mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Bus-side transaction engine directly downstream of the bus arbiter.
- Consumes the arbiter's bus_grant1 (instruction cache) and bus_grant2 (data cache) and latches the granted requester's line address and direction.
- Runs one fixed-length burst read or write to the memory interface, returns read beats to the owning cache, and pulses a per-owner done.
- Handles exactly one outstanding transaction at a time.

Parameters:
ADDR_W, 64, request/memory address width
DATA_W, 64, data beat width
BEATS, 8, beats per cache-line burst (power of two, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
bus_grant1  in  1  arbiter grant to instruction cache
bus_grant2  in  1  arbiter grant to data cache
ic_addr  in  ADDR_W  I-cache miss address
dc_addr  in  ADDR_W  D-cache request address
dc_we  in  1  D-cache request is writeback (1) or fill (0)
dc_wdata  in  DATA_W  D-cache write beat indexed by wr_beat
wr_beat  out  $clog2(BEATS)  index of write beat currently requested from D-cache
mem_req  out  1  address-phase request
mem_addr  out  ADDR_W  line-aligned burst address
mem_we  out  1  burst direction
mem_ack  in  1  address phase accepted
mem_wdata  out  DATA_W  write beat
mem_wvalid  out  1  write beat valid
mem_wready  in  1  memory accepts write beat
mem_rdata  in  DATA_W  read beat
mem_rvalid  in  1  read beat valid
resp_data  out  DATA_W  registered read beat to caches
resp_valid1  out  1  resp_data valid for I-cache
resp_valid2  out  1  resp_data valid for D-cache
done1  out  1  one-cycle completion pulse, I-cache
done2  out  1  one-cycle completion pulse, D-cache

Behaviour:
- Reset (reset low, async): state IDLE; beat counter 0; all outputs 0, including mem_addr, resp_data and wr_beat. Release is synchronous to clk. Reset mid-burst abandons the transfer; no done is issued.
- Address alignment: the low $clog2(BEATS*DATA_W/8) address bits are forced to 0 when latched.
- I-cache transactions are always reads.

State machine:
- IDLE
  - bus_grant2 high: latch owner=DC, dc_addr, dc_we; go to ADDR.
  - Else bus_grant1 high: latch owner=IC, ic_addr, we=0; go to ADDR.
  - Both grants high: DC wins, matching arbiter priority.
- ADDR
  - mem_req=1; mem_addr and mem_we held stable until mem_ack.
  - On mem_ack: mem_req drops the next cycle; go to RD if we=0, WR if we=1.
  - mem_ack outside ADDR is ignored.
- RD
  - Each cycle with mem_rvalid: resp_data<=mem_rdata and the owner's resp_valid pulses the next cycle (1-cycle latency); beat counter increments.
  - On beat BEATS-1: go to DONE.
  - mem_rvalid may be non-contiguous.
- WR
  - mem_wvalid=1, mem_wdata=dc_wdata (combinational pass-through), wr_beat=counter.
  - Beat completes on mem_wvalid&&mem_wready; counter increments.
  - After beat BEATS-1 is accepted: go to DONE.
  - mem_wdata must be held while mem_wready is low.
- DONE
  - The owner's done pulses for exactly one cycle; counter clears; go to RELEASE.
- RELEASE
  - Wait until the owner's grant is low; the arbiter grant is registered and lags the bid drop. Then go to IDLE.
  - Prevents a stale grant from restarting a transaction.
- Grant deasserted mid-transaction (ADDR/RD/WR): ignored. The burst completes and done still pulses.
- The beat counter is $clog2(BEATS) bits; the terminal beat is count==BEATS-1. Wrap-around to 0 occurs only in DONE.
- At most one of resp_valid1/resp_valid2 and one of done1/done2 is high in any cycle.
- Minimum read latency, grant to done: ADDR (>=1 cycle) + BEATS rvalid cycles + 1.

Decomposition:
- Shared package: state enum {IDLE, ADDR, RD, WR, DONE, RELEASE}, owner enum {OWN_IC, OWN_DC}, and localparams for the line-offset bit count and BEATS.
- The arbiter should import the same owner encoding.
- One natural sub-module: beat_counter (clear/increment/terminal-flag).

Test Plan:
- I-cache fill: bus_grant1=1, ic_addr=0x1038; mem_ack after 2 cycles; 8 contiguous rvalid beats 0xA0..0xA7 -> mem_addr=0x1000, mem_we=0; resp_valid1 on 8 cycles each carrying the matching beat; done1 one cycle after the last resp; resp_valid2 and done2 never high.
- D-cache writeback with stalls: bus_grant2=1, dc_we=1, dc_addr=0x2000; mem_wready toggling 1,0,1,0... -> wr_beat steps 0..7 only on accepted beats; mem_wdata stable during stalls; done2 after beat 7.
- Simultaneous grants in IDLE: bus_grant1=bus_grant2=1, dc_addr=0x3040, dc_we=0 -> mem_addr=0x3040, owner DC, resp_valid2 only.
- Lingering grant: bus_grant1 held high 3 cycles after done1 -> no second mem_req until grant1 low and then high again.
- Async reset mid-read after beat 4: reset low between clock edges -> all outputs 0 immediately; no done; after release, a new grant starts a fresh burst with wr_beat/counter at 0.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types for the bus-side transaction engine and its neighbours.
//   state_t : transaction engine states
//   owner_t : which cache owns the current transaction (shared with the arbiter)
//   line_off_bits() : number of byte-offset bits inside one cache line
package mem_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RD,
    WR,
    DONE,
    RELEASE
  } state_t;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } owner_t;

  localparam int unsigned ADDR_W_DEFAULT = 64;
  localparam int unsigned DATA_W_DEFAULT = 64;
  localparam int unsigned BEATS_DEFAULT  = 8;

  function automatic int unsigned line_off_bits(input int unsigned beats,
                                                input int unsigned data_w);
    return $clog2(beats * data_w / 8);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_beat_counter.sv
// Beat counter for one cache-line burst.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : return count to 0 (has priority over inc)
//   inc        : advance one beat
//   count      : current beat index
//   last       : count is the terminal beat (BEATS-1)
// The counter holds at the terminal beat; it only returns to 0 through clr.
module mem_bus_ctrl_beat_counter #(
  parameter int unsigned BEATS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(BEATS)-1:0] count,
  output logic                     last
);

  localparam int unsigned CNT_W = $clog2(BEATS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    last = (count == CNT_W'(BEATS - 1));
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus-side transaction engine downstream of the bus arbiter.
// Latches the granted requester (D-cache wins ties), runs one fixed-length
// burst read or write to memory, returns read beats to the owning cache and
// pulses the owner's done.
//   clk, reset              : clock, asynchronous active-low reset
//   bus_grant1 / bus_grant2 : arbiter grants, I-cache / D-cache
//   ic_addr                 : I-cache miss address (always a read)
//   dc_addr, dc_we          : D-cache address and direction (1 = writeback)
//   dc_wdata, wr_beat       : D-cache write beat, indexed by wr_beat
//   mem_req/addr/we/ack     : memory address phase
//   mem_wdata/wvalid/wready : memory write beats
//   mem_rdata/rvalid        : memory read beats
//   resp_data, resp_valid1/2: registered read beat and per-owner valid
//   done1 / done2           : one-cycle completion pulse per owner
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned BEATS  = BEATS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bus_grant1,
  input  logic                     bus_grant2,
  input  logic [ADDR_W-1:0]        ic_addr,
  input  logic [ADDR_W-1:0]        dc_addr,
  input  logic                     dc_we,
  input  logic [DATA_W-1:0]        dc_wdata,
  output logic [$clog2(BEATS)-1:0] wr_beat,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  input  logic                     mem_ack,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_wvalid,
  input  logic                     mem_wready,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_valid1,
  output logic                     resp_valid2,
  output logic                     done1,
  output logic                     done2
);

  localparam int unsigned OFF_BITS = line_off_bits(BEATS, DATA_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_BITS) - 64'd1);

  state_t              state_q, state_d;
  owner_t              owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic                owner_gnt;
  logic                cnt_clr, cnt_inc, cnt_last;

  mem_bus_ctrl_beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (wr_beat),
    .last  (cnt_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    owner_gnt = (owner_q == OWN_DC) ? bus_grant2 : bus_grant1;
  end

  // Next-state logic. RELEASE waits for the owner's registered grant to
  // fall so a lagging grant cannot start a second transaction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_grant2 || bus_grant1) state_d = ADDR;
      ADDR:    if (mem_ack) state_d = we_q ? WR : RD;
      RD:      if (mem_rvalid && cnt_last) state_d = DONE;
      WR:      if (mem_wready && cnt_last) state_d = DONE;
      DONE:    state_d = RELEASE;
      RELEASE: if (!owner_gnt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs and counter control
  always_comb begin
    mem_req    = 1'b0;
    mem_wvalid = 1'b0;
    mem_wdata  = '0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    case (state_q)
      ADDR: mem_req = 1'b1;
      RD:   cnt_inc = mem_rvalid;
      WR: begin
        mem_wvalid = 1'b1;
        mem_wdata  = dc_wdata;
        cnt_inc    = mem_wready;
      end
      DONE:    cnt_clr = 1'b1;
      default: ;
    endcase
  end

  // Request latch, read-beat return and done pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= OWN_IC;
      addr_q      <= '0;
      we_q        <= 1'b0;
      resp_data   <= '0;
      resp_valid1 <= 1'b0;
      resp_valid2 <= 1'b0;
      done1       <= 1'b0;
      done2       <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (bus_grant2) begin
          owner_q <= OWN_DC;
          addr_q  <= dc_addr & ~OFF_MASK;
          we_q    <= dc_we;
        end else if (bus_grant1) begin
          owner_q <= OWN_IC;
          addr_q  <= ic_addr & ~OFF_MASK;
          we_q    <= 1'b0;
        end
      end
      if (state_q == RD && mem_rvalid) begin
        resp_data <= mem_rdata;
      end
      resp_valid1 <= (state_q == RD) && mem_rvalid && (owner_q == OWN_IC);
      resp_valid2 <= (state_q == RD) && mem_rvalid && (owner_q == OWN_DC);
      done1       <= (state_q == DONE) && (owner_q == OWN_IC);
      done2       <= (state_q == DONE) && (owner_q == OWN_DC);
    end
  end

  always_comb begin
    mem_addr = addr_q;
    mem_we   = we_q;
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_grant1, bus_grant2;
  logic [63:0] ic_addr, dc_addr;
  logic        dc_we;
  logic [63:0] dc_wdata;
  logic [2:0]  wr_beat;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic        mem_ack;
  logic [63:0] mem_wdata;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic [63:0] resp_data;
  logic        resp_valid1, resp_valid2;
  logic        done1, done2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // D-cache model: write beat k carries 0xD000 + k.
  assign dc_wdata = 64'hD000 + 64'(wr_beat);

  mem_bus_ctrl #(
    .ADDR_W (64),
    .DATA_W (64),
    .BEATS  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_grant1  (bus_grant1),
    .bus_grant2  (bus_grant2),
    .ic_addr     (ic_addr),
    .dc_addr     (dc_addr),
    .dc_we       (dc_we),
    .dc_wdata    (dc_wdata),
    .wr_beat     (wr_beat),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .mem_wdata   (mem_wdata),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .resp_data   (resp_data),
    .resp_valid1 (resp_valid1),
    .resp_valid2 (resp_valid2),
    .done1       (done1),
    .done2       (done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read_beats(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 64'(i);
      tick();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_grant1 = 0; bus_grant2 = 0; ic_addr = '0; dc_addr = '0; dc_we = 0;
    mem_ack = 0; mem_wready = 0; mem_rdata = '0; mem_rvalid = 0;
    #2;
    checks++;
    if ({mem_req, mem_we, mem_wvalid, resp_valid1, resp_valid2, done1, done2} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {mem_req, mem_we, mem_wvalid, resp_valid1, resp_valid2, done1, done2});
    end
    checks++;
    if (mem_addr !== 64'h0 || resp_data !== 64'h0 || mem_wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%0h resp=%0h wdata=%0h expected 0", mem_addr, resp_data, mem_wdata);
    end
    checks++;
    if (wr_beat !== 3'd0) begin
      errors++;
      $display("FAIL reset_wr_beat: got %0d expected 0", wr_beat);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ic_fill();
    bus_grant1 = 1; ic_addr = 64'h1038;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h1000 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL ic_addr_phase: req=%b addr=%0h we=%b expected 1/1000/0", mem_req, mem_addr, mem_we);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin
      errors++;
      $display("FAIL ic_addr_hold: req=%b addr=%0h expected 1/1000", mem_req, mem_addr);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL ic_req_drop: got %b expected 0", mem_req);
    end
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1; mem_rdata = 64'hA0 + 64'(i);
      tick();
      checks++;
      if (resp_valid1 !== 1'b1 || resp_valid2 !== 1'b0 || resp_data !== 64'hA0 + 64'(i) ||
          done1 !== 1'b0 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL ic_beat%0d: v1=%b v2=%b data=%0h d1=%b d2=%b expected 1/0/%0h/0/0",
                 i, resp_valid1, resp_valid2, resp_data, done1, done2, 64'hA0 + 64'(i));
      end
    end
    mem_rvalid = 0;
    tick();
    checks++;
    if (done1 !== 1'b1 || done2 !== 1'b0 || resp_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL ic_done: d1=%b d2=%b v1=%b expected 1/0/0", done1, done2, resp_valid1);
    end
    bus_grant1 = 0;
    tick();
    checks++;
    if (done1 !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL ic_done_pulse: d1=%b req=%b expected 0/0", done1, mem_req);
    end
    tick();
  endtask

  task automatic test_dc_writeback();
    int exp_beat;
    bus_grant2 = 1; dc_we = 1; dc_addr = 64'h2000;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h2000 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL dc_addr_phase: req=%b addr=%0h we=%b expected 1/2000/1", mem_req, mem_addr, mem_we);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    exp_beat = 0;
    // wready pattern 1,0,1,0,... : every second cycle is a stall
    for (int s = 0; s < 15; s++) begin
      mem_wready = (s % 2 == 0);
      #1;
      checks++;
      if (mem_wvalid !== 1'b1 || wr_beat !== 3'(exp_beat) || mem_wdata !== 64'hD000 + 64'(exp_beat)) begin
        errors++;
        $display("FAIL dc_wr_step%0d: wvalid=%b beat=%0d wdata=%0h expected 1/%0d/%0h",
                 s, mem_wvalid, wr_beat, mem_wdata, exp_beat, 64'hD000 + 64'(exp_beat));
      end
      tick();
      if (mem_wready) exp_beat++;
    end
    mem_wready = 0;
    checks++;
    if (mem_wvalid !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL dc_wr_end: wvalid=%b d2=%b expected 0/0", mem_wvalid, done2);
    end
    tick();
    checks++;
    if (done2 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL dc_done: d2=%b d1=%b expected 1/0", done2, done1);
    end
    bus_grant2 = 0; dc_we = 0;
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    bus_grant1 = 1; bus_grant2 = 1; ic_addr = 64'h5000; dc_addr = 64'h3040; dc_we = 0;
    tick();
    checks++;
    if (mem_addr !== 64'h3040 || mem_we !== 1'b0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL sim_addr: addr=%0h we=%b req=%b expected 3040/0/1", mem_addr, mem_we, mem_req);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1; mem_rdata = 64'hB0 + 64'(i);
      tick();
      checks++;
      if (resp_valid2 !== 1'b1 || resp_valid1 !== 1'b0 || resp_data !== 64'hB0 + 64'(i)) begin
        errors++;
        $display("FAIL sim_beat%0d: v2=%b v1=%b data=%0h expected 1/0/%0h",
                 i, resp_valid2, resp_valid1, resp_data, 64'hB0 + 64'(i));
      end
    end
    mem_rvalid = 0;
    tick();
    checks++;
    if (done2 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL sim_done: d2=%b d1=%b expected 1/0", done2, done1);
    end
    bus_grant1 = 0; bus_grant2 = 0;
    tick();
    tick();
  endtask

  task automatic test_lingering_grant();
    bus_grant1 = 1; ic_addr = 64'h4000;
    tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    drive_read_beats(64'hC0, 8);
    tick();
    checks++;
    if (done1 !== 1'b1) begin
      errors++;
      $display("FAIL linger_done: got %b expected 1", done1);
    end
    // grant stays high; a stray mem_ack must also be ignored
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1;
      tick();
      checks++;
      if (mem_req !== 1'b0 || mem_rvalid !== 1'b0 && resp_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL linger_hold%0d: req=%b expected 0", i, mem_req);
      end
    end
    mem_ack = 0;
    bus_grant1 = 0;
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL linger_low: req=%b expected 0", mem_req);
    end
    bus_grant1 = 1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h4000) begin
      errors++;
      $display("FAIL linger_restart: req=%b addr=%0h expected 1/4000", mem_req, mem_addr);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    drive_read_beats(64'hC8, 8);
    tick();
    checks++;
    if (done1 !== 1'b1) begin
      errors++;
      $display("FAIL linger_done2: got %b expected 1", done1);
    end
    bus_grant1 = 0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_read();
    bus_grant1 = 1; ic_addr = 64'h6000;
    tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    drive_read_beats(64'hE0, 5);
    mem_rvalid = 1; mem_rdata = 64'hE5;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_wvalid, resp_valid1, resp_valid2, done1, done2} !== 7'b0 ||
        mem_addr !== 64'h0 || resp_data !== 64'h0 || wr_beat !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ctrl=%b addr=%0h resp=%0h beat=%0d expected all 0",
               {mem_req, mem_we, mem_wvalid, resp_valid1, resp_valid2, done1, done2},
               mem_addr, resp_data, wr_beat);
    end
    mem_rvalid = 0; bus_grant1 = 0;
    tick();
    tick();
    // fresh D-cache writeback after release must start at beat 0
    bus_grant2 = 1; dc_we = 1; dc_addr = 64'h7000;
    reset = 1'b1;
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: got %b expected 0", done1);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h7000 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart: req=%b addr=%0h we=%b expected 1/7000/1", mem_req, mem_addr, mem_we);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    mem_wready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_beat !== 3'(i) || mem_wdata !== 64'hD000 + 64'(i) || done1 !== 1'b0) begin
        errors++;
        $display("FAIL rst_wr_beat%0d: beat=%0d wdata=%0h d1=%b expected %0d/%0h/0",
                 i, wr_beat, mem_wdata, done1, i, 64'hD000 + 64'(i));
      end
      tick();
    end
    mem_wready = 0;
    tick();
    checks++;
    if (done2 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_done: d2=%b d1=%b expected 1/0", done2, done1);
    end
    bus_grant2 = 0; dc_we = 0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ic_fill();
    test_dc_writeback();
    test_simultaneous();
    test_lingering_grant();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
